// File: rtl/token_mult_pkg.sv
// Shared sizing helpers and parameter legality checks for the token multiplier.
package token_mult_pkg;

    function automatic int unsigned cred_max(input int unsigned max_run, input int unsigned mult);
        return max_run * (mult - 1);
    endfunction

    function automatic int unsigned cred_w(input int unsigned cmax);
        return (cmax < 1) ? 1 : $clog2(cmax + 1);
    endfunction

    function automatic bit params_ok(input int unsigned n_ch, input int unsigned mult,
                                     input int unsigned max_run);
        return (n_ch >= 1) && (mult >= 2) && (max_run >= 1);
    endfunction

endpackage

// File: rtl/token_mult_channel.sv
// One channel: credit counter, sticky overflow flag and combinational b/busy outputs.
module token_mult_channel
    import token_mult_pkg::*;
#(
    parameter int unsigned MULT    = 2,
    parameter int unsigned MAX_RUN = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic a_i,
    output logic b_o,
    output logic busy_o,
    output logic ovf_o
);

    localparam int unsigned CRED_MAX = cred_max(MAX_RUN, MULT);
    localparam int unsigned CRED_W   = cred_w(CRED_MAX);
    localparam logic [CRED_W:0] STEP  = (CRED_W+1)'(MULT - 1);
    localparam logic [CRED_W:0] LIMIT = (CRED_W+1)'(CRED_MAX);

    logic [CRED_W-1:0] credit_q, credit_d;
    logic              ovf_q, ovf_d;
    logic [CRED_W:0]   sum;
    logic              pending;

    assign pending = (credit_q != '0);
    assign sum     = {1'b0, credit_q} + STEP;

    // One extra bit on the add so a would-be wrap shows up as exceeding the limit.
    always_comb begin
        credit_d = credit_q;
        ovf_d    = ovf_q;
        if (!ovf_q) begin
            if (a_i) begin
                if (sum > LIMIT) begin
                    ovf_d    = 1'b1;
                    credit_d = '0;
                end else begin
                    credit_d = sum[CRED_W-1:0];
                end
            end else if (pending) begin
                credit_d = credit_q - CRED_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            credit_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            credit_q <= credit_d;
            ovf_q    <= ovf_d;
        end
    end

    assign b_o    = a_i | pending;
    assign busy_o = pending & ~ovf_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/token_multiplier.sv
// N-channel serial token expander: each input '1' yields MULT output '1's per channel.
module token_multiplier
    import token_mult_pkg::*;
#(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned MULT    = 2,
    parameter int unsigned MAX_RUN = 200
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] a,
    output logic [N_CH-1:0] b,
    output logic [N_CH-1:0] overflow,
    output logic            overflow_any,
    output logic [N_CH-1:0] busy
);

    if (!params_ok(N_CH, MULT, MAX_RUN)) begin : g_bad_params
        $error("token_multiplier: need N_CH>=1, MULT>=2, MAX_RUN>=1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        token_mult_channel #(
            .MULT    (MULT),
            .MAX_RUN (MAX_RUN)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .a_i    (a[i]),
            .b_o    (b[i]),
            .busy_o (busy[i]),
            .ovf_o  (overflow[i])
        );
    end

    assign overflow_any = |overflow;

endmodule
